// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The master side issues operations; the slave side is the adder itself.
interface serial_adder_if #(
   parameter int WIDTH = 4
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output start, a, b, cin, sub,
      input  busy, done, sum, cout, overflow
   );

   modport slave (
      input  start, a, b, cin, sub,
      output busy, done, sum, cout, overflow
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one sum/carry cell and a registered carry,
// processing one operand bit per clock, LSB first.
module serial_adder #(
   parameter int WIDTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] opa_r;
   logic [WIDTH-1:0] opb_r;
   logic [WIDTH-1:0] res_r;
   logic [WIDTH-1:0] sum_r;
   logic [CNT_W-1:0] cnt_r;
   logic             carry_r;
   logic             cout_r;
   logic             ovf_r;
   logic             busy_r;
   logic             done_r;
   logic             accept_s;
   logic             last_s;
   logic             bit_s;
   logic             carry_nxt_s;

   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   assign bit_s       = opa_r[0] ^ opb_r[0] ^ carry_r;
   assign carry_nxt_s = maj3(opa_r[0], opb_r[0], carry_r);
   assign last_s      = (cnt_r == LAST_CNT);

   // Next-state decode and start acceptance (only in IDLE or DONE).
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               accept_s    = 1'b1;
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DONE: begin
            if (bus.start) begin
               accept_s    = 1'b1;
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State register; busy/done are registered from the next state so they track it exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s == RUN);
         done_r  <= (state_nxt_s == DONE);
      end
   end

   // Operand latch, serial bit cell and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa_r   <= {WIDTH{1'b0}};
         opb_r   <= {WIDTH{1'b0}};
         res_r   <= {WIDTH{1'b0}};
         sum_r   <= {WIDTH{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         carry_r <= 1'b0;
         cout_r  <= 1'b0;
         ovf_r   <= 1'b0;
      end else if (accept_s) begin
         // Subtract is a + ~b + 1, so cin is ignored when sub is set.
         opa_r   <= bus.a;
         opb_r   <= bus.sub ? ~bus.b : bus.b;
         carry_r <= bus.sub ? 1'b1 : bus.cin;
         cnt_r   <= {CNT_W{1'b0}};
      end else if (state_r == RUN) begin
         opa_r   <= {1'b0, opa_r[WIDTH-1:1]};
         opb_r   <= {1'b0, opb_r[WIDTH-1:1]};
         res_r   <= {bit_s, res_r[WIDTH-1:1]};
         carry_r <= carry_nxt_s;
         cnt_r   <= cnt_r + CNT_ONE;
         if (last_s) begin
            // carry_r here is the carry into the MSB.
            sum_r  <= {bit_s, res_r[WIDTH-1:1]};
            cout_r <= carry_nxt_s;
            ovf_r  <= carry_r ^ carry_nxt_s;
         end
      end
   end

   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.sum      = sum_r;
   assign bus.cout     = cout_r;
   assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: constant vector table, exhaustive 4-bit
// add sweep, handshake/reset corner sequences and an 8-bit instance.
module tb_serial_adder;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(4)) bus4 ();
   serial_adder_if #(.WIDTH(8)) bus8 ();

   serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
   serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

   typedef struct {
      logic [31:0] s;
      logic        co;
      logic        ov;
   } exp_t;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      logic       sub;
      logic [3:0] s;
      logic       co;
      logic       ov;
   } vec_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: plain integer arithmetic, overflow from operand/result signs.
   function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub);
      logic [63:0] mask;
      logic [63:0] bb;
      logic [63:0] full;
      exp_t        e;
      mask = (64'd1 << w) - 64'd1;
      bb   = sub ? (~{32'd0, b} & mask) : {32'd0, b};
      full = {32'd0, a} + bb + (sub ? 64'd1 : {63'd0, cin});
      e.s  = full[31:0] & mask[31:0];
      e.co = full[w];
      e.ov = (a[w-1] == bb[w-1]) && (e.s[w-1] != a[w-1]);
      return e;
   endfunction

   // Drive an operation (caller is at a negedge), push expectation, scramble inputs after accept.
   task automatic accept4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                          input logic sub, input exp_t e);
      bus4.a     = a;
      bus4.b     = b;
      bus4.cin   = cin;
      bus4.sub   = sub;
      bus4.start = 1'b1;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      bus4.start = 1'b0;
      bus4.a     = ~a;
      bus4.b     = b ^ 4'b0101;
      bus4.cin   = ~cin;
      bus4.sub   = ~sub;
   endtask

   task automatic finish4(input int pre);
      int   lat;
      int   bc;
      logic seen;
      exp_t e;
      lat  = 0;
      bc   = pre;
      seen = 1'b0;
      for (int k = pre + 1; k <= 40; k++) begin
         @(negedge clk);
         chk("busy_done_exclusive", {31'd0, bus4.busy & bus4.done}, 32'd0);
         if (bus4.busy) bc++;
         if (bus4.done) begin
            lat  = k - 1;
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         chk("done_timeout", 32'd0, 32'd1);
      end else begin
         chk("latency4", lat, 32'd4);
         chk("busy_cycles4", bc, 32'd4);
         if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
         end else begin
            e = sb_q.pop_front();
            chk("sum4", {28'd0, bus4.sum}, e.s);
            chk("cout4", {31'd0, bus4.cout}, {31'd0, e.co});
            chk("overflow4", {31'd0, bus4.overflow}, {31'd0, e.ov});
         end
      end
   endtask

   vec_t tbl[8];

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   extra;
      int   lat8;
      logic seen8;
      exp_t e8;

      tbl[0] = '{4'd7,  4'd1, 1'b0, 1'b0, 4'd8,  1'b0, 1'b1};
      tbl[1] = '{4'd15, 4'd0, 1'b1, 1'b0, 4'd0,  1'b1, 1'b0};
      tbl[2] = '{4'd5,  4'd3, 1'b0, 1'b1, 4'd2,  1'b1, 1'b0};
      tbl[3] = '{4'd3,  4'd5, 1'b0, 1'b1, 4'd14, 1'b0, 1'b0};
      tbl[4] = '{4'd8,  4'd1, 1'b0, 1'b1, 4'd7,  1'b1, 1'b1};
      tbl[5] = '{4'd5,  4'd3, 1'b1, 1'b1, 4'd2,  1'b1, 1'b0};
      tbl[6] = '{4'd0,  4'd0, 1'b0, 1'b1, 4'd0,  1'b1, 1'b0};
      tbl[7] = '{4'd7,  4'd7, 1'b1, 1'b0, 4'd15, 1'b0, 1'b1};

      rst_n      = 1'b0;
      bus4.start = 1'b0; bus4.a = 4'd0; bus4.b = 4'd0; bus4.cin = 1'b0; bus4.sub = 1'b0;
      bus8.start = 1'b0; bus8.a = 8'd0; bus8.b = 8'd0; bus8.cin = 1'b0; bus8.sub = 1'b0;
      #12;
      chk("reset_busy", {31'd0, bus4.busy}, 32'd0);
      chk("reset_done", {31'd0, bus4.done}, 32'd0);
      chk("reset_sum", {28'd0, bus4.sum}, 32'd0);
      chk("reset_flags", {30'd0, bus4.cout, bus4.overflow}, 32'd0);
      chk("reset_sum8", {24'd0, bus8.sum}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Constant vectors: flag, subtract and cin-ignored cases.
      for (int i = 0; i < 8; i++) begin
         exp_t e;
         e.s  = {28'd0, tbl[i].s};
         e.co = tbl[i].co;
         e.ov = tbl[i].ov;
         @(negedge clk);
         accept4(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, e);
         finish4(0);
      end

      // Exhaustive 4-bit add sweep.
      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            @(negedge clk);
            accept4(4'(ai), 4'(bi), 1'b0, 1'b0, model(4, 32'(ai), 32'(bi), 1'b0, 1'b0));
            finish4(0);
         end
      end

      // start re-pulsed during RUN is ignored.
      @(negedge clk);
      accept4(4'd9, 4'd4, 1'b0, 1'b0, model(4, 32'd9, 32'd4, 1'b0, 1'b0));
      @(negedge clk);
      @(negedge clk);
      bus4.a     = 4'd1;
      bus4.b     = 4'd1;
      bus4.start = 1'b1;
      @(posedge clk);
      #1;
      bus4.start = 1'b0;
      finish4(2);
      extra = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus4.done) extra++;
      end
      chk("no_second_done", extra, 32'd0);
      chk("idle_after_done", {31'd0, bus4.busy}, 32'd0);

      // Back-to-back: start held in DONE starts the next op with no IDLE cycle.
      @(negedge clk);
      accept4(4'd2, 4'd3, 1'b0, 1'b0, model(4, 32'd2, 32'd3, 1'b0, 1'b0));
      finish4(0);
      accept4(4'd6, 4'd7, 1'b0, 1'b0, model(4, 32'd6, 32'd7, 1'b0, 1'b0));
      chk("b2b_busy_immediate", {31'd0, bus4.busy}, 32'd1);
      finish4(0);

      // Asynchronous reset mid-RUN.
      @(negedge clk);
      accept4(4'd5, 4'd6, 1'b0, 1'b0, model(4, 32'd5, 32'd6, 1'b0, 1'b0));
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_run_busy", {31'd0, bus4.busy}, 32'd0);
      chk("rst_run_done", {31'd0, bus4.done}, 32'd0);
      chk("rst_run_sum", {28'd0, bus4.sum}, 32'd0);
      chk("rst_run_cout", {31'd0, bus4.cout}, 32'd0);
      chk("rst_run_overflow", {31'd0, bus4.overflow}, 32'd0);
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      extra = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus4.done) extra++;
      end
      chk("no_done_after_abort", extra, 32'd0);
      accept4(4'd12, 4'd5, 1'b1, 1'b0, model(4, 32'd12, 32'd5, 1'b1, 1'b0));
      finish4(0);

      // 8-bit instance.
      @(negedge clk);
      bus8.a     = 8'd200;
      bus8.b     = 8'd100;
      bus8.cin   = 1'b0;
      bus8.sub   = 1'b0;
      bus8.start = 1'b1;
      e8.s  = 32'h2C;
      e8.co = 1'b1;
      e8.ov = 1'b0;
      sb_q.push_back(e8);
      @(posedge clk);
      #1;
      bus8.start = 1'b0;
      bus8.a     = 8'd0;
      lat8  = 0;
      seen8 = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus8.done) begin
            lat8  = k - 1;
            seen8 = 1'b1;
            break;
         end
      end
      if (!seen8) begin
         chk("done8_timeout", 32'd0, 32'd1);
      end else begin
         chk("latency8", lat8, 32'd8);
         e8 = sb_q.pop_front();
         chk("sum8", {24'd0, bus8.sum}, e8.s);
         chk("cout8", {31'd0, bus8.cout}, {31'd0, e8.co});
         chk("overflow8", {31'd0, bus8.overflow}, {31'd0, e8.ov});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised bit-serial adder/subtractor. It processes one bit per clock, LSB first, using a single sum/carry bit cell and a registered carry. It sits beside the ALU of the 4-bit processor simulator as the area-minimal arithmetic unit, and its WIDTH is generalised for wider datapaths. A start/busy/done handshake adds multi-cycle operation, carry-in, subtract mode and signed-overflow flags.

Parameters:
WIDTH, 4, operand and result width in bits; legal range 2 to 32.
CNT_W, $clog2(WIDTH)+1, bit counter width; derived localparam, not overridable.

Ports:
clk  input  1  rising-edge clock; the single clock of the block
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only in IDLE or DONE
a  input  WIDTH  operand A; latched on accepted start
b  input  WIDTH  operand B; latched on accepted start
cin  input  1  carry-in for add; latched on accepted start; ignored when sub=1
sub  input  1  0 = a+b+cin, 1 = a-b (computed as a+~b+1); latched on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  result; updated only on entry to DONE, then held
cout  output  1  carry out of MSB; for sub, 1 = no borrow
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, sum, cout, overflow = 0; internal shift registers, carry and counter = 0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at a rising edge goes to RUN. The same edge latches:
  - opA=a
  - opB = sub ? ~b : b
  - carry = sub ? 1 : cin
  - cnt=0
- RUN:
  - Each edge computes s = opA[0]^opB[0]^carry and c = majority(opA[0], opB[0], carry).
  - It shifts s into the result register MSB end, shifts opA/opB right by one, sets carry=c and increments cnt.
  - On the edge that processes bit WIDTH-1, it records the carry into the MSB for overflow.
  - On the edge where cnt reaches WIDTH-1, it transfers the result to sum and sets cout=c and overflow; next state is DONE.
- Latency: done is high in the cycle after the WIDTH-th rising edge following the start-accept edge (e.g. WIDTH=4: accept at edge 0, done visible after edge 4).
- DONE:
  - done=1 for exactly one cycle.
  - If start=1 in this cycle, the operation is accepted back-to-back and the next state is RUN. Otherwise the next state is IDLE.
  - sum, cout and overflow hold until the next completion.
- busy=1 in RUN only; done=1 in DONE only; never both high.
- start in RUN is ignored; there is no queueing.
- Changes on a, b, cin or sub after acceptance have no effect on the running operation.
- Reset asserted mid-RUN aborts the operation immediately: all outputs 0, and no done pulse is produced.
- All arithmetic is modulo 2^WIDTH; the result bits never depend on operand sign.

Test Plan:
1. WIDTH=4, all 256 (a,b) pairs with cin=0, sub=0, one at a time -> sum==(a+b)[3:0] and cout==(a+b)[4] at each done; done exactly 4 edges after accept; busy high 4 cycles.
2. WIDTH=4 flag cases:
   - a=7, b=1, add -> sum=4'b1000, cout=0, overflow=1.
   - a=15, b=0, cin=1 -> sum=0, cout=1, overflow=0.
3. WIDTH=4 subtract:
   - a=5, b=3 -> sum=4'b0010, cout=1.
   - a=3, b=5 -> sum=4'b1110, cout=0, overflow=0.
   - a=8, b=1 -> sum=4'b0111, overflow=1.
4. Handshake:
   - start re-pulsed during RUN -> ignored, single done.
   - start held high during DONE -> next operation begins with no IDLE cycle; a and b changed mid-RUN do not alter the result.
5. Reset: assert rst_n=0 after 2 RUN edges -> busy, done, sum, cout, overflow = 0 asynchronously (before the next clock edge); after release, a new start completes normally.
6. WIDTH=8 instance: a=200, b=100, add -> sum=8'h2C, cout=1, done 8 edges after accept.
